// File: rtl/sram_fault_model.sv
// sram_fault_model: 2**ADDR_W x DAT_W single-port synchronous SRAM model with
// a small fault table (stuck-at, transition, inversion coupling). A fault-free
// shadow array supplies the reference data used to count fault hits on reads.
module sram_fault_model #(
    parameter int ADDR_W     = 8,
    parameter int DAT_W      = 4,
    parameter int NUM_FAULTS = 4,
    parameter int CNT_W      = 16,
    localparam int BIT_W     = (DAT_W > 1) ? $clog2(DAT_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DAT_W-1:0]  dat_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              w_en,
    output logic [DAT_W-1:0]  read_d,
    input  logic              flt_ld,
    input  logic              flt_clr,
    input  logic [2:0]        flt_type,
    input  logic [ADDR_W-1:0] flt_vaddr,
    input  logic [BIT_W-1:0]  flt_vbit,
    input  logic [ADDR_W-1:0] flt_aaddr,
    input  logic [BIT_W-1:0]  flt_abit,
    output logic              flt_full,
    output logic              flt_err,
    output logic [CNT_W-1:0]  flt_hits
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(NUM_FAULTS + 1);

    localparam logic [2:0] FT_NONE = 3'd0;
    localparam logic [2:0] FT_SA0  = 3'd1;
    localparam logic [2:0] FT_SA1  = 3'd2;
    localparam logic [2:0] FT_TFU  = 3'd3;
    localparam logic [2:0] FT_TFD  = 3'd4;
    localparam logic [2:0] FT_CFIN = 3'd5;

    typedef struct packed {
        logic              vld;
        logic [2:0]        typ;
        logic [ADDR_W-1:0] va;
        logic [BIT_W-1:0]  vb;
        logic [ADDR_W-1:0] aa;
        logic [BIT_W-1:0]  ab;
    } slot_t;

    slot_t [NUM_FAULTS-1:0] slot_q, slot_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       hits_q, hits_d;
    logic [DAT_W-1:0]       rdat_q, rdat_d;
    logic [DAT_W-1:0]       mem_q  [DEPTH];
    logic [DAT_W-1:0]       mem_d  [DEPTH];
    logic [DAT_W-1:0]       gold_q [DEPTH];
    logic [DAT_W-1:0]       gold_d [DEPTH];

    logic [DAT_W-1:0] old_word, wr_word, rd_word;
    logic             cf_hit, rd_vic, hit, ld_bad;

    assign read_d   = rdat_q;
    assign flt_full = (ptr_q == PTR_W'(NUM_FAULTS));
    assign flt_err  = err_q;
    assign flt_hits = hits_q;

    // Write path: apply victim faults in slot order, then coupling inversions.
    always_comb begin
        old_word = mem_q[addr_in];
        wr_word  = dat_in;
        cf_hit   = 1'b0;
        mem_d    = mem_q;
        gold_d   = gold_q;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (slot_q[i].vld && slot_q[i].va == addr_in) begin
                case (slot_q[i].typ)
                    FT_SA0: wr_word[slot_q[i].vb] = 1'b0;
                    FT_SA1: wr_word[slot_q[i].vb] = 1'b1;
                    FT_TFU: if (!old_word[slot_q[i].vb] && wr_word[slot_q[i].vb])
                                wr_word[slot_q[i].vb] = 1'b0;
                    FT_TFD: if (old_word[slot_q[i].vb] && !wr_word[slot_q[i].vb])
                                wr_word[slot_q[i].vb] = 1'b1;
                    default: ;
                endcase
            end
        end
        if (w_en) begin
            mem_d[addr_in]  = wr_word;
            gold_d[addr_in] = dat_in;
            // Toggle is judged on what actually lands in the aggressor cell.
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (slot_q[i].vld && slot_q[i].typ == FT_CFIN && slot_q[i].aa == addr_in &&
                    old_word[slot_q[i].ab] != wr_word[slot_q[i].ab]) begin
                    mem_d[slot_q[i].va][slot_q[i].vb] = ~mem_d[slot_q[i].va][slot_q[i].vb];
                    cf_hit = 1'b1;
                end
            end
        end
    end

    // Read path: stuck-at overlay on the stored word; hits only at faulted victims.
    always_comb begin
        rd_word = mem_q[addr_in];
        rd_vic  = 1'b0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (slot_q[i].vld && slot_q[i].va == addr_in) begin
                rd_vic = 1'b1;
                if (slot_q[i].typ == FT_SA0) rd_word[slot_q[i].vb] = 1'b0;
                if (slot_q[i].typ == FT_SA1) rd_word[slot_q[i].vb] = 1'b1;
            end
        end
        rdat_d = w_en ? rdat_q : rd_word;
        hit    = w_en ? (wr_word != dat_in || cf_hit)
                      : (rd_vic && rd_word != gold_q[addr_in]);
    end

    // Fault table management and saturating hit counter.
    always_comb begin
        slot_d = slot_q;
        ptr_d  = ptr_q;
        err_d  = 1'b0;
        hits_d = hits_q;
        ld_bad = flt_full || flt_type == FT_NONE || flt_type > FT_CFIN ||
                 (flt_type == FT_CFIN && flt_aaddr == flt_vaddr);
        if (hit && hits_q != '1) hits_d = hits_q + 1'b1;
        if (flt_clr) begin
            slot_d = '0;
            ptr_d  = '0;
            hits_d = '0;
        end else if (flt_ld) begin
            if (ld_bad) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_FAULTS; i++) begin
                    if (ptr_q == PTR_W'(i))
                        slot_d[i] = '{vld: 1'b1, typ: flt_type, va: flt_vaddr,
                                      vb: flt_vbit, aa: flt_aaddr, ab: flt_abit};
                end
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // State registers; reset clears array, shadow, table and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]  <= '0;
                gold_q[i] <= '0;
            end
            slot_q <= '0;
            ptr_q  <= '0;
            err_q  <= 1'b0;
            hits_q <= '0;
            rdat_q <= '0;
        end else begin
            mem_q  <= mem_d;
            gold_q <= gold_d;
            slot_q <= slot_d;
            ptr_q  <= ptr_d;
            err_q  <= err_d;
            hits_q <= hits_d;
            rdat_q <= rdat_d;
        end
    end
endmodule

// File: tb/tb_sram_fault_model.sv
// Directed bench for sram_fault_model; read expectations go through a queue
// and are popped one clock after the read is issued.
module tb_sram_fault_model;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  dat_in;
    logic [7:0]  addr_in;
    logic        w_en;
    logic [3:0]  read_d;
    logic        flt_ld, flt_clr;
    logic [2:0]  flt_type;
    logic [7:0]  flt_vaddr, flt_aaddr;
    logic [1:0]  flt_vbit, flt_abit;
    logic        flt_full, flt_err;
    logic [15:0] flt_hits;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    logic [3:0]  exp_q[$];
    logic        rd_issue = 1'b0;

    sram_fault_model dut (
        .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .addr_in(addr_in), .w_en(w_en),
        .read_d(read_d), .flt_ld(flt_ld), .flt_clr(flt_clr), .flt_type(flt_type),
        .flt_vaddr(flt_vaddr), .flt_vbit(flt_vbit), .flt_aaddr(flt_aaddr),
        .flt_abit(flt_abit), .flt_full(flt_full), .flt_err(flt_err), .flt_hits(flt_hits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Idle = read of 0x00, which never carries a fault.
    task automatic idle();
        w_en = 1'b0; addr_in = 8'h00; dat_in = 4'h0;
        flt_ld = 1'b0; flt_clr = 1'b0; rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] d);
        @(negedge clk);
        w_en = 1'b1; addr_in = a; dat_in = d;
        @(posedge clk); #1 idle();
    endtask

    task automatic rd(input logic [7:0] a, input logic [3:0] e);
        @(negedge clk);
        w_en = 1'b0; addr_in = a; rd_issue = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1 idle();
    endtask

    task automatic ld(input logic [2:0] t, input logic [7:0] va, input logic [1:0] vb,
                      input logic [7:0] aa, input logic [1:0] ab,
                      input logic clr, input logic exp_err);
        @(negedge clk);
        flt_ld = 1'b1; flt_clr = clr; flt_type = t;
        flt_vaddr = va; flt_vbit = vb; flt_aaddr = aa; flt_abit = ab;
        @(posedge clk); #1;
        chk("flt_err", flt_err, exp_err);
        idle();
    endtask

    // Read-data monitor: compares read_d one cycle after each read.
    always @(posedge clk) begin
        if (rd_issue) begin
            #1;
            if (exp_q.size() == 0) chk("rd_queue", exp_q.size(), 1);
            else chk("read_d", read_d, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flt_type = 3'd0; flt_vaddr = 8'h0; flt_vbit = 2'd0;
        flt_aaddr = 8'h0; flt_abit = 2'd0;
        idle();
        #12;
        chk("rst_read_d", read_d, 4'h0);
        chk("rst_hits", flt_hits, 16'd0);
        chk("rst_full", flt_full, 1'b0);
        chk("rst_err", flt_err, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // No faults
        wr(8'h00, 4'hA); wr(8'hFF, 4'h5);
        rd(8'h00, 4'hA); rd(8'hFF, 4'h5);
        @(negedge clk); chk("hits_nofault", flt_hits, 16'd0);

        // SA1 at 0x10 bit 0
        ld(3'd2, 8'h10, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0);
        wr(8'h10, 4'h0); rd(8'h10, 4'h1);
        @(negedge clk); chk("hits_sa1", flt_hits, 16'd2);

        // TF-up at 0x20 bit 3, TF-down at 0x21 bit 0
        ld(3'd3, 8'h20, 2'd3, 8'h00, 2'd0, 1'b0, 1'b0);
        wr(8'h20, 4'h0); wr(8'h20, 4'hF); rd(8'h20, 4'h7);
        ld(3'd4, 8'h21, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0);
        wr(8'h21, 4'hF); wr(8'h21, 4'h0); rd(8'h21, 4'h1);
        @(negedge clk); chk("hits_tf", flt_hits, 16'd6);
        chk("full_3", flt_full, 1'b0);

        // CFin: aggressor 0x30 bit 1, victim 0x31 bit 2
        ld(3'd5, 8'h31, 2'd2, 8'h30, 2'd1, 1'b0, 1'b0);
        chk("full_4", flt_full, 1'b1);
        wr(8'h31, 4'h0); wr(8'h30, 4'h0); wr(8'h30, 4'h2);
        rd(8'h31, 4'h4);
        wr(8'h30, 4'h2);
        rd(8'h31, 4'h4); rd(8'h30, 4'h2);
        @(negedge clk); chk("hits_cfin", flt_hits, 16'd9);

        // Capacity and rejection
        ld(3'd1, 8'h50, 2'd0, 8'h00, 2'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("err_one_cycle", flt_err, 1'b0);
        chk("full_after_rej", flt_full, 1'b1);
        wr(8'h50, 4'hF); rd(8'h50, 4'hF);
        ld(3'd1, 8'h50, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0);
        chk("full_after_clr", flt_full, 1'b0);
        chk("hits_after_clr", flt_hits, 16'd0);
        ld(3'd0, 8'h50, 2'd0, 8'h00, 2'd0, 1'b0, 1'b1);
        ld(3'd6, 8'h50, 2'd0, 8'h00, 2'd0, 1'b0, 1'b1);
        ld(3'd5, 8'h60, 2'd0, 8'h60, 2'd1, 1'b0, 1'b1);
        rd(8'h20, 4'h7);
        rd(8'h10, 4'h1);
        @(negedge clk); chk("hits_empty_tbl", flt_hits, 16'd0);

        // Reset mid-write
        ld(3'd1, 8'h40, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0);
        wr(8'h40, 4'hF); rd(8'h40, 4'hE);
        @(negedge clk); chk("hits_sa0", flt_hits, 16'd2);
        chk("full_pre_rst", flt_full, 1'b0);
        w_en = 1'b1; addr_in = 8'h41; dat_in = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk("async_read_d", read_d, 4'h0);
        chk("async_hits", flt_hits, 16'd0);
        @(negedge clk); idle(); rst_n = 1'b1;
        rd(8'h00, 4'h0); rd(8'h41, 4'h0); rd(8'h20, 4'h0);
        @(negedge clk);
        chk("rd_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_fault_model.md
Name: sram_fault_model

Overview:
- Memory-side responder for the March BIST controller: a 256x4 single-port synchronous SRAM model with a programmable fault table.
- Answers the controller's address/data/write-enable traffic like the plain SRAM does, but corrupts stored or read data according to the loaded faults.
- Lets the bench prove that the March algorithm detects stuck-at, transition and inversion-coupling faults.
- Sits between the BIST controller outputs (dat_out, addr_out, w_en_out) and the controller's dat_in.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- DAT_W, 4, data word width.
- NUM_FAULTS, 4, fault table slots.
- CNT_W, 16, width of the saturating fault-hit counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dat_in  in  DAT_W  write data from the BIST controller.
- addr_in  in  ADDR_W  access address.
- w_en  in  1  1 = write cycle, 0 = read cycle.
- read_d  out  DAT_W  registered read data to the controller.
- flt_ld  in  1  one-cycle pulse; loads one fault into the next free slot.
- flt_clr  in  1  one-cycle pulse; empties the fault table.
- flt_type  in  3  0 none, 1 SA0, 2 SA1, 3 TF-up (0->1 fails), 4 TF-down (1->0 fails), 5 CFin; 6-7 invalid.
- flt_vaddr  in  ADDR_W  victim address.
- flt_vbit  in  clog2(DAT_W)  victim bit index.
- flt_aaddr  in  ADDR_W  aggressor address (CFin only).
- flt_abit  in  clog2(DAT_W)  aggressor bit index (CFin only).
- flt_full  out  1  high when all NUM_FAULTS slots are valid.
- flt_err  out  1  one-cycle pulse when a load is rejected.
- flt_hits  out  CNT_W  count of cycles in which an active fault changed array or read data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Array cleared to 0; all slots invalid; slot pointer 0.
  - read_d=0, flt_full=0, flt_err=0, flt_hits=0.
  - Reset mid-access aborts the access; no partial write.
- Write (w_en=1):
  - Next array word = dat_in with faults applied in slot order; a higher slot wins on the same bit.
  - SA0 forces the bit to 0; SA1 forces it to 1.
  - TF-up: the bit stays 0 if old=0 and new=1.
  - TF-down: the bit stays 1 if old=1 and new=0.
  - CFin: if the write to flt_aaddr toggles bit flt_abit, victim bit flt_vbit at flt_vaddr is inverted in the same edge.
  - A victim word is never written in the same cycle its CFin aggressor is written (single port).
  - read_d holds its value during write cycles.
- Read (w_en=0): read_d <= array[addr_in] with the SA0/SA1 overlay applied; latency is exactly 1 clock.
- Fault table:
  - flt_ld stores the fault into the slot at the pointer, marks it valid, and increments the pointer.
  - flt_ld is rejected (flt_err=1 for one cycle, table unchanged) on any of: table full, flt_type of 0/6/7, or CFin with flt_aaddr==flt_vaddr.
  - flt_clr invalidates all slots and zeroes the pointer and flt_hits; it does not touch the array.
  - flt_clr has priority over flt_ld in the same cycle; that load is dropped silently.
  - A newly loaded fault affects accesses from the next cycle onward; existing cell contents are not retroactively modified.
- flt_full = (pointer == NUM_FAULTS).
- flt_hits:
  - +1 in any cycle where faulted data != fault-free data for the written word, the CFin victim, or the read word.
  - Saturates at all-ones; no wrap.
- Address wraps naturally; there are no out-of-range addresses.

Test Plan:
- No faults: write 0xA to 0x00 and 0x5 to 0xFF, then read both -> read_d=0xA and then 0x5, each one cycle after the read; flt_hits=0.
- SA1 at vaddr 0x10, bit 0: write 0x0 to 0x10, read 0x10 -> read_d=0x1; flt_hits=2 (write and read).
- TF-up at 0x20, bit 3: write 0x0, write 0xF, read -> read_d=0x7. TF-down at 0x21, bit 0: write 0xF, write 0x0, read -> read_d=0x1.
- CFin with aggressor 0x30 bit 1 and victim 0x31 bit 2: write 0x0 to 0x31, then 0x0 and 0x2 to 0x30, read 0x31 -> read_d=0x4; a second write of 0x2 to 0x30 (no toggle) -> victim unchanged.
- Table capacity with NUM_FAULTS=4: 4 valid loads -> flt_full=1; 5th load -> flt_err pulses one cycle, table unchanged; flt_clr and flt_ld in the same cycle -> table empty, flt_full=0, no flt_err.
- Drop rst_n asynchronously between clock edges mid-write -> read_d=0 and flt_hits=0 immediately; after release, any read returns 0x0.
